silencer: RTL and testbench

SILENCER -- requirements
Module: silencer

---
 rtl/silencer_pkg.sv | 19 +
 rtl/silencer_step_calculator.sv | 79 +++++++
 rtl/silencer.sv | 112 +++++++++++
 tb/tb_silencer.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/silencer_pkg.sv
// Shared definitions for the silencer: pipeline depth, per-transducer state record and
// the arithmetic width helper used by the step calculators.
package silencer_pkg;

    localparam int unsigned PipeLatency = 3;
    localparam int unsigned StateWidth  = 16;
    localparam int unsigned StepWidth   = 16;

    typedef struct packed {
        logic [StateWidth-1:0] duty;
        logic [StateWidth-1:0] phase;
    } state_t;

    // Wide enough for +/- 2*value and for the largest step without overflow.
    function automatic int unsigned arith_width(input int unsigned w);
        return (w + 2 > StepWidth + 2) ? w + 2 : StepWidth + 2;
    endfunction

endpackage

// File: rtl/silencer_step_calculator.sv
// Step limiter: S2 registers the (optionally wrapped) difference, S3 output is the
// combinational step-limited next value derived from the S2 registers.
module step_calculator
    import silencer_pkg::*;
#(
    parameter int unsigned WIDTH = 13
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 wrap_en_i,
    input  logic [WIDTH-1:0]     cur_i,
    input  logic [WIDTH-1:0]     tgt_i,
    input  logic [WIDTH-1:0]     cycle_i,
    input  logic [StepWidth-1:0] step_i,
    output logic [WIDTH-1:0]     next_o
);

    localparam int unsigned AW   = arith_width(WIDTH);
    localparam int unsigned PadW = AW - WIDTH;

    typedef logic signed [AW-1:0] sval_t;

    function automatic sval_t ext(input logic [WIDTH-1:0] v);
        return $signed({{PadW{1'b0}}, v});
    endfunction

    sval_t raw, cyc_s, diff_d, diff_q, abs_d, step_s, cyc_q_s, next_s;
    logic [WIDTH-1:0] cur_q, tgt_q, cyc_q;

    always_comb begin
        raw    = ext(tgt_i) - ext(cur_i);
        cyc_s  = ext(cycle_i);
        diff_d = raw;
        // Normalise into (-cycle/2, cycle/2]; an exact half-cycle stays positive.
        if (wrap_en_i) begin
            if ((raw <<< 1) > cyc_s) begin
                diff_d = raw - cyc_s;
            end else if ((raw <<< 1) <= -cyc_s) begin
                diff_d = raw + cyc_s;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            diff_q <= '0;
            cur_q  <= '0;
            tgt_q  <= '0;
            cyc_q  <= '0;
        end else if (en_i) begin
            diff_q <= diff_d;
            cur_q  <= cur_i;
            tgt_q  <= tgt_i;
            cyc_q  <= cycle_i;
        end
    end

    always_comb begin
        abs_d   = diff_q[AW-1] ? -diff_q : diff_q;
        step_s  = $signed({{(AW-StepWidth){1'b0}}, step_i});
        cyc_q_s = ext(cyc_q);
        if (abs_d <= step_s) begin
            next_s = ext(tgt_q);
        end else begin
            next_s = diff_q[AW-1] ? ext(cur_q) - step_s : ext(cur_q) + step_s;
            if (wrap_en_i) begin
                if (next_s < 0) begin
                    next_s = next_s + cyc_q_s;
                end else if (next_s >= cyc_q_s) begin
                    next_s = next_s - cyc_q_s;
                end
            end
        end
    end

    assign next_o = next_s[WIDTH-1:0];

endmodule

// File: rtl/silencer.sv
// Per-transducer duty/phase slew limiter: 3-stage pipeline tracking the last emitted
// value of every transducer and moving it toward the target by at most one step per frame.
module silencer
    import silencer_pkg::*;
#(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 249
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [StepWidth-1:0] STEP_DUTY,
    input  logic [StepWidth-1:0] STEP_PHASE,
    input  logic [WIDTH-1:0]     CYCLE [DEPTH],
    input  logic                 DIN_VALID,
    input  logic [WIDTH-1:0]     DUTY_IN,
    input  logic [WIDTH-1:0]     PHASE_IN,
    output logic [WIDTH-1:0]     DUTY_OUT,
    output logic [WIDTH-1:0]     PHASE_OUT,
    output logic                 DOUT_VALID
);

    localparam int unsigned IW = $clog2(DEPTH);

    logic [IW-1:0]          idx_q, idx_d, s1_idx_q, s2_idx_q;
    logic [PipeLatency-1:0] vld_q;
    state_t                 state_q [DEPTH];
    state_t                 s1_cur_q;
    logic [WIDTH-1:0]       s1_duty_tgt_q, s1_phase_tgt_q, s1_cycle_q;
    logic [WIDTH-1:0]       cycle_sel, phase_tgt_d;
    logic [WIDTH-1:0]       duty_next, phase_next;
    logic [WIDTH-1:0]       duty_out_q, phase_out_q;

    always_comb begin
        idx_d = idx_q;
        if (DIN_VALID) begin
            idx_d = (idx_q == IW'(DEPTH - 1)) ? '0 : idx_q + 1'b1;
        end
        cycle_sel   = CYCLE[idx_q];
        phase_tgt_d = (PHASE_IN >= cycle_sel) ? PHASE_IN - cycle_sel : PHASE_IN;
    end

    // DEPTH >= 3 means an index is re-read no earlier than the cycle after its write-back.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx_q          <= '0;
            vld_q          <= '0;
            s1_idx_q       <= '0;
            s2_idx_q       <= '0;
            s1_cur_q       <= '0;
            s1_duty_tgt_q  <= '0;
            s1_phase_tgt_q <= '0;
            s1_cycle_q     <= '0;
            duty_out_q     <= '0;
            phase_out_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                state_q[i] <= '0;
            end
        end else begin
            idx_q <= idx_d;
            vld_q <= {vld_q[PipeLatency-2:0], DIN_VALID};
            if (DIN_VALID) begin
                s1_idx_q       <= idx_q;
                s1_cur_q       <= state_q[idx_q];
                s1_duty_tgt_q  <= DUTY_IN;
                s1_phase_tgt_q <= phase_tgt_d;
                s1_cycle_q     <= cycle_sel;
            end
            if (vld_q[0]) begin
                s2_idx_q <= s1_idx_q;
            end
            if (vld_q[1]) begin
                duty_out_q               <= duty_next;
                phase_out_q              <= phase_next;
                state_q[s2_idx_q].duty   <= StateWidth'(duty_next);
                state_q[s2_idx_q].phase  <= StateWidth'(phase_next);
            end
        end
    end

    step_calculator #(
        .WIDTH (WIDTH)
    ) u_duty_step (
        .clk_i     (CLK),
        .rst_i     (RST),
        .en_i      (vld_q[0]),
        .wrap_en_i (1'b0),
        .cur_i     (s1_cur_q.duty[WIDTH-1:0]),
        .tgt_i     (s1_duty_tgt_q),
        .cycle_i   (s1_cycle_q),
        .step_i    (STEP_DUTY),
        .next_o    (duty_next)
    );

    step_calculator #(
        .WIDTH (WIDTH)
    ) u_phase_step (
        .clk_i     (CLK),
        .rst_i     (RST),
        .en_i      (vld_q[0]),
        .wrap_en_i (1'b1),
        .cur_i     (s1_cur_q.phase[WIDTH-1:0]),
        .tgt_i     (s1_phase_tgt_q),
        .cycle_i   (s1_cycle_q),
        .step_i    (STEP_PHASE),
        .next_o    (phase_next)
    );

    assign DUTY_OUT   = duty_out_q;
    assign PHASE_OUT  = phase_out_q;
    assign DOUT_VALID = vld_q[PipeLatency-1];

endmodule

// File: tb/tb_silencer.sv
// Directed bench for the silencer: duty ramp, phase wrap and tie, valid gaps,
// mid-frame reset and zero-step freeze.
module tb_silencer;

    localparam int W = 13;
    localparam int D = 249;

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   step_duty, step_phase;
    logic [W-1:0]  cycle_arr [D];
    logic          din_valid;
    logic [W-1:0]  duty_in, phase_in;
    logic [W-1:0]  duty_out, phase_out;
    logic          dout_valid;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] q_duty[$];
    logic [W-1:0] q_phase[$];

    always #5 clk = ~clk;

    silencer #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .CLK        (clk),
        .RST        (rst),
        .STEP_DUTY  (step_duty),
        .STEP_PHASE (step_phase),
        .CYCLE      (cycle_arr),
        .DIN_VALID  (din_valid),
        .DUTY_IN    (duty_in),
        .PHASE_IN   (phase_in),
        .DUTY_OUT   (duty_out),
        .PHASE_OUT  (phase_out),
        .DOUT_VALID (dout_valid)
    );

    always @(negedge clk) begin
        if (!rst && dout_valid) begin
            q_duty.push_back(duty_out);
            q_phase.push_back(phase_out);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
                 checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic push(input logic v, input logic [W-1:0] d, input logic [W-1:0] p);
        @(negedge clk);
        din_valid = v;
        duty_in   = d;
        phase_in  = p;
    endtask

    task automatic push_frame(input logic [W-1:0] d, input logic [W-1:0] p);
        for (int i = 0; i < D; i++) push(1'b1, d, p);
    endtask

    task automatic drain();
        repeat (6) push(1'b0, '0, '0);
    endtask

    task automatic clear_q();
        q_duty.delete();
        q_phase.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_q();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (duty_out !== '0) begin
            failures++; $display("FAIL reset_duty: got %0d expected 0", duty_out);
        end
        checks++;
        if (phase_out !== '0) begin
            failures++; $display("FAIL reset_phase: got %0d expected 0", phase_out);
        end
        checks++;
        if (dout_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got %0b expected 0", dout_valid);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (dout_valid !== 1'b0 || duty_out !== '0) begin
            failures++;
            $display("FAIL reset_idle: got valid=%0b duty=%0d expected valid=0 duty=0",
                     dout_valid, duty_out);
        end
    endtask

    task automatic test_duty_ramp();
        int exp;
        do_reset();
        step_duty  = 16'd10;
        step_phase = 16'd0;
        for (int f = 0; f < 11; f++) push_frame(13'd100, 13'd0);
        drain();
        checks++;
        if (q_duty.size() != 11 * D) begin
            failures++;
            $display("FAIL ramp_count: got %0d outputs expected %0d", q_duty.size(), 11 * D);
        end
        for (int k = 0; k < 11; k++) begin
            exp = (10 * (k + 1) > 100) ? 100 : 10 * (k + 1);
            checks++;
            if (q_duty[k * D] !== W'(exp)) begin
                failures++;
                $display("FAIL ramp_t0_frame%0d: got %0d expected %0d", k, q_duty[k * D], exp);
            end
        end
        checks++;
        if (q_duty[4 * D + D - 1] !== 13'd50) begin
            failures++;
            $display("FAIL ramp_tlast_frame4: got %0d expected 50", q_duty[4 * D + D - 1]);
        end
        checks++;
        if (q_phase[0] !== 13'd0) begin
            failures++; $display("FAIL ramp_phase: got %0d expected 0", q_phase[0]);
        end
    endtask

    task automatic test_phase_wrap();
        do_reset();
        step_duty  = 16'd0;
        step_phase = 16'hFFFF;
        push_frame(13'd0, 13'd4090);
        drain();
        checks++;
        if (q_phase[0] !== 13'd4090) begin
            failures++; $display("FAIL wrap_preload: got %0d expected 4090", q_phase[0]);
        end
        clear_q();
        step_phase = 16'd8;
        push_frame(13'd0, 13'd10);
        // Target above CYCLE is reduced once to 10.
        push_frame(13'd0, 13'd4106);
        drain();
        checks++;
        if (q_phase[0] !== 13'd2) begin
            failures++; $display("FAIL wrap_step1: got %0d expected 2", q_phase[0]);
        end
        checks++;
        if (q_phase[D] !== 13'd10) begin
            failures++; $display("FAIL wrap_step2: got %0d expected 10", q_phase[D]);
        end
    endtask

    task automatic test_phase_tie();
        do_reset();
        step_duty  = 16'd0;
        step_phase = 16'd1000;
        for (int f = 0; f < 3; f++) push_frame(13'd0, 13'd2048);
        drain();
        checks++;
        if (q_phase[0] !== 13'd1000) begin
            failures++; $display("FAIL tie_f0: got %0d expected 1000", q_phase[0]);
        end
        checks++;
        if (q_phase[D] !== 13'd2000) begin
            failures++; $display("FAIL tie_f1: got %0d expected 2000", q_phase[D]);
        end
        checks++;
        if (q_phase[2 * D] !== 13'd2048) begin
            failures++; $display("FAIL tie_f2: got %0d expected 2048", q_phase[2 * D]);
        end
    endtask

    task automatic test_valid_gaps();
        logic [7:0] pat;
        logic [7:0] dv;
        logic [W-1:0] held;
        pat = 8'b0000_1001;
        do_reset();
        step_duty  = 16'hFFFF;
        step_phase = 16'd0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            dv[i] = dout_valid;
            if (i == 4) held = duty_out;
            din_valid = pat[i];
            duty_in   = pat[i] ? ((i == 0) ? 13'd5 : 13'd7) : 13'd123;
            phase_in  = '0;
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dv[i] !== ((i >= 3) ? pat[i - 3] : 1'b0)) begin
                failures++;
                $display("FAIL gap_valid_c%0d: got %0b expected %0b", i, dv[i],
                         (i >= 3) ? pat[i - 3] : 1'b0);
            end
        end
        checks++;
        if (held !== 13'd5) begin
            failures++; $display("FAIL gap_hold: got %0d expected 5", held);
        end
        checks++;
        if (q_duty.size() != 2 || q_duty[0] !== 13'd5 || q_duty[1] !== 13'd7) begin
            failures++;
            $display("FAIL gap_values: got n=%0d %0d,%0d expected n=2 5,7",
                     q_duty.size(), q_duty[0], q_duty[1]);
        end
        // Finish the frame from index 2, then probe indices 0..2 with a unit step.
        for (int i = 0; i < D - 2; i++) push(1'b1, 13'd0, 13'd0);
        drain();
        clear_q();
        step_duty = 16'd1;
        push_frame(13'd0, 13'd0);
        drain();
        checks++;
        if (q_duty[0] !== 13'd4 || q_duty[1] !== 13'd6 || q_duty[2] !== 13'd0) begin
            failures++;
            $display("FAIL gap_index: got %0d,%0d,%0d expected 4,6,0",
                     q_duty[0], q_duty[1], q_duty[2]);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        step_duty  = 16'hFFFF;
        step_phase = 16'hFFFF;
        for (int i = 0; i < 100; i++) push(1'b1, 13'd50, 13'd300);
        @(negedge clk);
        checks++;
        if (dout_valid !== 1'b1 || duty_out !== 13'd50) begin
            failures++;
            $display("FAIL midrst_pre: got valid=%0b duty=%0d expected valid=1 duty=50",
                     dout_valid, duty_out);
        end
        rst       = 1'b1;
        din_valid = 1'b1;
        #1;
        checks++;
        if (dout_valid !== 1'b0 || duty_out !== '0 || phase_out !== '0) begin
            failures++;
            $display("FAIL midrst_out: got valid=%0b duty=%0d phase=%0d expected 0,0,0",
                     dout_valid, duty_out, phase_out);
        end
        @(negedge clk);
        din_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        clear_q();
        step_duty  = 16'd1;
        step_phase = 16'd1;
        push_frame(13'd50, 13'd300);
        drain();
        checks++;
        if (q_duty.size() != D) begin
            failures++; $display("FAIL midrst_count: got %0d expected %0d", q_duty.size(), D);
        end
        checks++;
        if (q_duty[0] !== 13'd1 || q_phase[0] !== 13'd1) begin
            failures++;
            $display("FAIL midrst_t0: got duty=%0d phase=%0d expected 1,1",
                     q_duty[0], q_phase[0]);
        end
        checks++;
        if (q_duty[99] !== 13'd1) begin
            failures++; $display("FAIL midrst_t99: got %0d expected 1", q_duty[99]);
        end
    endtask

    task automatic test_freeze();
        do_reset();
        step_duty  = 16'd0;
        step_phase = 16'd0;
        for (int i = 0; i < 4; i++) push(1'b1, 13'd777, 13'd123);
        drain();
        checks++;
        if (q_duty.size() != 4) begin
            failures++; $display("FAIL freeze_count: got %0d expected 4", q_duty.size());
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (q_duty[i] !== '0 || q_phase[i] !== '0) begin
                failures++;
                $display("FAIL freeze_zero%0d: got duty=%0d phase=%0d expected 0,0",
                         i, q_duty[i], q_phase[i]);
            end
        end
        do_reset();
        step_duty  = 16'hFFFF;
        step_phase = 16'hFFFF;
        push_frame(13'd40, 13'd60);
        drain();
        clear_q();
        step_duty  = 16'd0;
        step_phase = 16'd0;
        push_frame(13'd999, 13'd888);
        drain();
        checks++;
        if (q_duty[0] !== 13'd40 || q_phase[0] !== 13'd60) begin
            failures++;
            $display("FAIL freeze_hold_t0: got duty=%0d phase=%0d expected 40,60",
                     q_duty[0], q_phase[0]);
        end
        checks++;
        if (q_duty[D - 1] !== 13'd40 || q_phase[D - 1] !== 13'd60) begin
            failures++;
            $display("FAIL freeze_hold_tlast: got duty=%0d phase=%0d expected 40,60",
                     q_duty[D - 1], q_phase[D - 1]);
        end
    endtask

    initial begin
        rst        = 1'b1;
        din_valid  = 1'b0;
        duty_in    = '0;
        phase_in   = '0;
        step_duty  = '0;
        step_phase = '0;
        for (int i = 0; i < D; i++) cycle_arr[i] = 13'd4096;
        test_reset();
        test_duty_ramp();
        test_phase_wrap();
        test_phase_tie();
        test_valid_gaps();
        test_mid_reset();
        test_freeze();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
